mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single memory port between instruction fetch (IFU) and load/store (LSU) as the core moves from single-cycle to multi-cycle operation. It grants one transaction at a time using round-robin priority, tracks the single outstanding request, and routes the memory response back to its owner. A watchdog aborts a transaction whose response never arrives.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Tracks a single outstanding transaction and aborts it via a watchdog if no response arrives.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   if_req_addr,
    output logic                    if_req_ready,
    output logic                    if_resp_valid,
    output logic [DATA_WIDTH-1:0]   if_resp_data,
    input  logic                    ls_req_valid,
    input  logic [ADDR_WIDTH-1:0]   ls_req_addr,
    input  logic                    ls_req_wen,
    input  logic [DATA_WIDTH-1:0]   ls_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] ls_req_wmask,
    output logic                    ls_req_ready,
    output logic                    ls_resp_valid,
    output logic [DATA_WIDTH-1:0]   ls_resp_data,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_wen,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wmask,
    input  logic                    mem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   mem_resp_data,
    output logic                    err
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          r_state;
    logic            r_owner;   // 0 = IFU, 1 = LSU
    logic            r_rr_ptr;  // requester favoured on a tie
    logic [WD_W-1:0] r_wd_cnt;
    logic            r_err;

    logic w_idle;
    logic w_wait;
    logic w_if_win;
    logic w_ls_win;
    logic w_grant;

    // Arbitration is re-evaluated every IDLE cycle, so a stalled grant never locks.
    always_comb begin
        w_idle   = (r_state == S_IDLE) && !rst;
        w_wait   = (r_state == S_WAIT) && !rst;
        w_if_win = w_idle && if_req_valid && (!ls_req_valid || !r_rr_ptr);
        w_ls_win = w_idle && ls_req_valid && (!if_req_valid || r_rr_ptr);
        w_grant  = (w_if_win || w_ls_win) && mem_req_ready;
    end

    assign mem_req_valid = w_if_win || w_ls_win;
    assign if_req_ready  = w_if_win && mem_req_ready;
    assign ls_req_ready  = w_ls_win && mem_req_ready;
    assign mem_addr      = w_ls_win ? ls_req_addr : (w_if_win ? if_req_addr : '0);
    assign mem_wen       = w_ls_win && ls_req_wen;
    assign mem_wdata     = w_ls_win ? ls_req_wdata : '0;
    assign mem_wmask     = w_ls_win ? ls_req_wmask : '0;

    assign if_resp_valid = w_wait && mem_resp_valid && !r_owner;
    assign ls_resp_valid = w_wait && mem_resp_valid && r_owner;
    assign if_resp_data  = mem_resp_data;
    assign ls_resp_data  = mem_resp_data;
    assign err           = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_rr_ptr <= 1'b0;
            r_wd_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Any response with nothing outstanding is spurious.
                    r_err <= mem_resp_valid;
                    if (w_grant) begin
                        r_owner  <= w_ls_win;
                        r_rr_ptr <= w_if_win;
                        r_wd_cnt <= '0;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_resp_valid) begin
                        r_err   <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_wd_cnt == WD_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_err    <= 1'b0;
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a randomized
// run checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid;
    logic [AW-1:0] if_req_addr;
    logic          if_req_ready;
    logic          if_resp_valid;
    logic [DW-1:0] if_resp_data;
    logic          ls_req_valid;
    logic [AW-1:0] ls_req_addr;
    logic          ls_req_wen;
    logic [DW-1:0] ls_req_wdata;
    logic [7:0]    ls_req_wmask;
    logic          ls_req_ready;
    logic          ls_resp_valid;
    logic [DW-1:0] ls_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_wen;
    logic [DW-1:0] mem_wdata;
    logic [7:0]    mem_wmask;
    logic          mem_resp_valid;
    logic [DW-1:0] mem_resp_data;
    logic          err;

    mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_addr   (if_req_addr),
        .if_req_ready  (if_req_ready),
        .if_resp_valid (if_resp_valid),
        .if_resp_data  (if_resp_data),
        .ls_req_valid  (ls_req_valid),
        .ls_req_addr   (ls_req_addr),
        .ls_req_wen    (ls_req_wen),
        .ls_req_wdata  (ls_req_wdata),
        .ls_req_wmask  (ls_req_wmask),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .ls_resp_data  (ls_resp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .err           (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, a priority holder, elapsed wait count.
    bit m_busy  = 0;
    int m_owner = 0;   // 0 = IFU, 1 = LSU
    int m_prio  = 0;   // who wins a tie
    int m_wait  = 0;   // wait cycles elapsed without response
    bit m_err   = 0;
    bit chk_en  = 0;
    int e_win;

    function automatic int pick_winner();
        if (if_req_valid && ls_req_valid) return m_prio;
        if (if_req_valid) return 0;
        if (ls_req_valid) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_prio = 0; m_wait = 0; m_err = 0;
        end else if (!m_busy) begin
            m_err = mem_resp_valid;
            w = pick_winner();
            if (w >= 0 && mem_req_ready) begin
                m_busy = 1; m_owner = w; m_prio = 1 - w; m_wait = 0;
            end
        end else if (mem_resp_valid) begin
            m_busy = 0; m_err = 0;
        end else begin
            m_wait++;
            m_err = 0;
            if (m_wait == TO) begin
                m_busy = 0; m_err = 1;
            end
        end
        chk_en = 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            if (rst) begin
                chk1("m_rst_mem_valid", mem_req_valid, 1'b0);
                chk1("m_rst_if_ready", if_req_ready, 1'b0);
                chk1("m_rst_ls_ready", ls_req_ready, 1'b0);
                chk1("m_rst_if_resp", if_resp_valid, 1'b0);
                chk1("m_rst_ls_resp", ls_resp_valid, 1'b0);
            end else if (!m_busy) begin
                e_win = pick_winner();
                chk1("m_mem_valid", mem_req_valid, e_win >= 0);
                chk1("m_if_ready", if_req_ready, e_win == 0 && mem_req_ready);
                chk1("m_ls_ready", ls_req_ready, e_win == 1 && mem_req_ready);
                if (e_win == 0) begin
                    chk64("m_addr_if", mem_addr, if_req_addr);
                    chk1("m_wen_if", mem_wen, 1'b0);
                    chk64("m_wdata_if", mem_wdata, 64'h0);
                    chk64("m_wmask_if", 64'(mem_wmask), 64'h0);
                end else if (e_win == 1) begin
                    chk64("m_addr_ls", mem_addr, ls_req_addr);
                    chk1("m_wen_ls", mem_wen, ls_req_wen);
                    chk64("m_wdata_ls", mem_wdata, ls_req_wdata);
                    chk64("m_wmask_ls", 64'(mem_wmask), 64'(ls_req_wmask));
                end
                chk1("m_idle_if_resp", if_resp_valid, 1'b0);
                chk1("m_idle_ls_resp", ls_resp_valid, 1'b0);
            end else begin
                chk1("m_wait_mem_valid", mem_req_valid, 1'b0);
                chk1("m_wait_if_ready", if_req_ready, 1'b0);
                chk1("m_wait_ls_ready", ls_req_ready, 1'b0);
                chk64("m_wait_addr", mem_addr, 64'h0);
                chk1("m_wait_wen", mem_wen, 1'b0);
                chk1("m_if_resp", if_resp_valid, mem_resp_valid && m_owner == 0);
                chk1("m_ls_resp", ls_resp_valid, mem_resp_valid && m_owner == 1);
                if (mem_resp_valid && m_owner == 0) chk64("m_if_data", if_resp_data, mem_resp_data);
                if (mem_resp_valid && m_owner == 1) chk64("m_ls_data", ls_resp_data, mem_resp_data);
            end
            chk1("m_err", err, m_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    bit hs_if, hs_ls;
    int p_resp;

    initial begin
        rst = 1; if_req_valid = 1; if_req_addr = '0;
        ls_req_valid = 0; ls_req_addr = '0; ls_req_wen = 0; ls_req_wdata = '0; ls_req_wmask = '0;
        mem_req_ready = 1; mem_resp_valid = 1; mem_resp_data = '0;

        // Reset state
        neg();
        chk1("rst_if_ready", if_req_ready, 1'b0);
        chk1("rst_mem_valid", mem_req_valid, 1'b0);
        chk1("rst_if_resp", if_resp_valid, 1'b0);
        step();
        neg();
        chk1("rst_err", err, 1'b0);
        step();
        rst = 0; if_req_valid = 0; mem_resp_valid = 0;

        // Single IFU fetch
        if_req_valid = 1; if_req_addr = 64'h8000_0000;
        neg();
        chk1("fetch_ready", if_req_ready, 1'b1);
        chk1("fetch_ls_ready", ls_req_ready, 1'b0);
        chk64("fetch_addr", mem_addr, 64'h8000_0000);
        chk1("fetch_wen", mem_wen, 1'b0);
        step();
        if_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 64'h0010_0093;
        neg();
        chk1("fetch_resp", if_resp_valid, 1'b1);
        chk64("fetch_data", if_resp_data, 64'h0010_0093);
        chk1("fetch_ls_resp", ls_resp_valid, 1'b0);
        step();
        mem_resp_valid = 0;

        // Fresh reset so the IFU is favoured on the first tie
        rst = 1;
        step();
        rst = 0;

        // Simultaneous requests alternate IFU, LSU, IFU, LSU
        if_req_valid = 1; ls_req_valid = 1; ls_req_addr = 64'h8000_1000; ls_req_wen = 0;
        for (int g = 0; g < 4; g++) begin
            neg();
            chk1("rr_if_ready", if_req_ready, (g % 2) == 0);
            chk1("rr_ls_ready", ls_req_ready, (g % 2) == 1);
            chk64("rr_addr", mem_addr, ((g % 2) == 1) ? 64'h8000_1000 : 64'h8000_0000);
            step();
            mem_resp_valid = 1; mem_resp_data = 64'hA0 + 64'(g);
            neg();
            chk1("rr_if_resp", if_resp_valid, (g % 2) == 0);
            chk1("rr_ls_resp", ls_resp_valid, (g % 2) == 1);
            chk1("rr_no_grant_in_resp", mem_req_valid, 1'b0);
            step();
            mem_resp_valid = 0;
        end
        if_req_valid = 0; ls_req_valid = 0;

        // LSU store
        ls_req_valid = 1; ls_req_wen = 1; ls_req_addr = 64'h8000_2000;
        ls_req_wdata = 64'h1122_3344_5566_7788; ls_req_wmask = 8'h0F;
        neg();
        chk1("st_ready", ls_req_ready, 1'b1);
        chk1("st_wen", mem_wen, 1'b1);
        chk64("st_wmask", 64'(mem_wmask), 64'h0F);
        chk64("st_wdata", mem_wdata, 64'h1122_3344_5566_7788);
        step();
        ls_req_valid = 0; mem_resp_valid = 1;
        neg();
        chk1("st_resp", ls_resp_valid, 1'b1);
        chk1("st_if_resp", if_resp_valid, 1'b0);
        step();
        mem_resp_valid = 0; ls_req_wen = 0; ls_req_wmask = '0; ls_req_wdata = '0;

        // One IFU transaction hands priority to the LSU
        if_req_valid = 1; if_req_addr = 64'h8000_0004;
        neg();
        chk1("pre_bp_ready", if_req_ready, 1'b1);
        step();
        if_req_valid = 0; mem_resp_valid = 1;
        step();
        mem_resp_valid = 0;

        // Backpressure: LSU overtakes a stalled IFU request
        mem_req_ready = 0; if_req_valid = 1; if_req_addr = 64'h8000_0008; ls_req_addr = 64'h8000_3000;
        for (int c = 0; c < 2; c++) begin
            neg();
            chk64("bp_addr_if", mem_addr, 64'h8000_0008);
            chk1("bp_if_ready", if_req_ready, 1'b0);
            step();
        end
        ls_req_valid = 1;
        neg();
        chk64("bp_addr_ls", mem_addr, 64'h8000_3000);
        chk1("bp_ls_ready0", ls_req_ready, 1'b0);
        step();
        mem_req_ready = 1;
        neg();
        chk1("bp_ls_ready", ls_req_ready, 1'b1);
        chk1("bp_if_ready1", if_req_ready, 1'b0);
        step();
        ls_req_valid = 0; mem_resp_valid = 1;
        neg();
        chk1("bp_ls_resp", ls_resp_valid, 1'b1);
        step();
        mem_resp_valid = 0;

        // Watchdog: the still-pending IFU request is granted, then never answered
        neg();
        chk1("wd_grant", if_req_ready, 1'b1);
        step();
        if_req_valid = 0;
        for (int w = 0; w < TO; w++) begin
            neg();
            chk1("wd_wait_err", err, 1'b0);
            chk1("wd_wait_resp", if_resp_valid, 1'b0);
            step();
        end
        if_req_valid = 1; mem_req_ready = 0;
        neg();
        chk1("wd_err_pulse", err, 1'b1);
        chk1("wd_back_idle", mem_req_valid, 1'b1);
        step();
        mem_req_ready = 1;
        neg();
        chk1("wd_err_once", err, 1'b0);
        chk1("wd_regrant", if_req_ready, 1'b1);
        step();
        if_req_valid = 0;
        for (int w = 0; w < TO - 1; w++) begin
            neg();
            chk1("wd2_wait_resp", if_resp_valid, 1'b0);
            step();
        end
        mem_resp_valid = 1; mem_resp_data = 64'h5A5A;
        neg();
        chk1("wd_last_resp", if_resp_valid, 1'b1);
        chk64("wd_last_data", if_resp_data, 64'h5A5A);
        step();
        mem_resp_valid = 0;
        neg();
        chk1("wd_last_no_err", err, 1'b0);
        step();

        // Reset mid-WAIT, then a late response is spurious
        if_req_valid = 1; if_req_addr = 64'h8000_0010;
        neg();
        chk1("rw_grant", if_req_ready, 1'b1);
        step();
        if_req_valid = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0; mem_resp_valid = 1;
        neg();
        chk1("rw_if_resp", if_resp_valid, 1'b0);
        chk1("rw_ls_resp", ls_resp_valid, 1'b0);
        step();
        mem_resp_valid = 0;
        neg();
        chk1("rw_err", err, 1'b1);
        step();
        if_req_valid = 1;
        neg();
        chk1("rw_err_once", err, 1'b0);
        chk1("rw_next_grant", if_req_ready, 1'b1);
        step();
        if_req_valid = 0; mem_resp_valid = 1; mem_resp_data = 64'h77;
        neg();
        chk1("rw_next_resp", if_resp_valid, 1'b1);
        step();
        mem_resp_valid = 0;

        // Randomized traffic; requesters hold payload until accepted
        for (int ph = 0; ph < 2; ph++) begin
            p_resp = (ph == 0) ? 40 : 4;
            for (int c = 0; c < 2000; c++) begin
                neg();
                hs_if = if_req_ready;
                hs_ls = ls_req_ready;
                step();
                rst = ($urandom_range(0, 199) == 0);
                if (!if_req_valid || hs_if) begin
                    if_req_valid = 1'($urandom_range(0, 1));
                    if_req_addr  = {$urandom, $urandom};
                end
                if (!ls_req_valid || hs_ls) begin
                    ls_req_valid = 1'($urandom_range(0, 1));
                    ls_req_addr  = {$urandom, $urandom};
                    ls_req_wen   = 1'($urandom_range(0, 1));
                    ls_req_wdata = {$urandom, $urandom};
                    ls_req_wmask = 8'($urandom_range(0, 255));
                end
                mem_req_ready  = ($urandom_range(0, 9) < 7);
                mem_resp_valid = ($urandom_range(0, 99) < p_resp);
                mem_resp_data  = {$urandom, $urandom};
            end
        end
        neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
